// File: rtl/mpmc10_state_seq.sv
// mpmc10 command/data sequencer: runs one granted burst of single-beat commands on the MIG user interface.
// Optional stall watchdog enabled by defining MPMC10_SEQ_TIMEOUT_EN (default build: no watchdog, err tied low).
module mpmc10_state_seq #(
    parameter int LENW    = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            calib_done,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [LENW-1:0] req_len,
    output logic            req_ack,
    output logic            app_en,
    output logic [2:0]      app_cmd,
    input  logic            app_rdy,
    output logic            app_wdf_wren,
    output logic            app_wdf_end,
    input  logic            app_wdf_rdy,
    input  logic            rd_data_valid,
    output logic [LENW-1:0] beat_idx,
    output logic [3:0]      state,
    output logic            done,
    output logic            err
);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        PRESET1     = 4'd1,
        PRESET2     = 4'd2,
        WRITE_DATA0 = 4'd3,
        WRITE_DATA1 = 4'd4,
        WRITE_DATA2 = 4'd5,
        READ_DATA0  = 4'd6,
        READ_DATA1  = 4'd7,
        READ_DATA2  = 4'd8,
        WAIT_NACK   = 4'd9
    } seq_state_t;

    localparam logic [LENW:0]   CNT_ONE  = (LENW+1)'(1);
    localparam logic [LENW-1:0] BEAT_ONE = LENW'(1);

    seq_state_t      cur_state;
    seq_state_t      next_state;
    logic            we_q;
    logic [LENW-1:0] len_q;
    logic [LENW:0]   len_ext;
    logic [LENW:0]   cmd_cnt;
    logic [LENW:0]   rd_cnt;
    logic [LENW:0]   rd_total;
    logic [LENW-1:0] beat_q;
    logic            last_cmd;
    logic            rd_all;
    logic            rd_phase;
    logic            timeout_hit;

    // Counters carry one extra bit so a full 2^LENW burst compares cleanly.
    assign len_ext  = {1'b0, len_q};
    assign last_cmd = (cmd_cnt == len_ext);
    assign rd_phase = (cur_state == READ_DATA0) || (cur_state == READ_DATA1);
    assign rd_total = rd_cnt + {{LENW{1'b0}}, rd_data_valid};
    assign rd_all   = (rd_total > len_ext);
    assign beat_idx = beat_q;
    assign state    = cur_state;

`ifdef MPMC10_SEQ_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] stall_cnt;

    assign timeout_hit = (stall_cnt == SW'(TIMEOUT));

    // Watchdog restarts whenever the sequencer makes progress or is parked.
    always_ff @(posedge clk) begin
        if (!rstn || (next_state != cur_state) ||
            (cur_state == IDLE) || (cur_state == WAIT_NACK)) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + SW'(1);
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE:        if (calib_done && req_valid) next_state = PRESET1;
            PRESET1:     next_state = PRESET2;
            PRESET2:     next_state = we_q ? WRITE_DATA0 : READ_DATA0;
            WRITE_DATA0: if (app_wdf_rdy) next_state = WRITE_DATA1;
            WRITE_DATA1: if (app_rdy) next_state = WRITE_DATA2;
            WRITE_DATA2: next_state = last_cmd ? WAIT_NACK : WRITE_DATA0;
            READ_DATA0:  if (app_rdy && last_cmd) next_state = READ_DATA1;
            READ_DATA1:  if (rd_all) next_state = READ_DATA2;
            READ_DATA2:  next_state = WAIT_NACK;
            WAIT_NACK:   if (!req_valid) next_state = IDLE;
            default:     next_state = IDLE;
        endcase
        if (timeout_hit) next_state = IDLE;
    end

    // Read beats may overtake the command stream, so they are counted in both read states.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            we_q    <= 1'b0;
            len_q   <= '0;
            cmd_cnt <= '0;
            rd_cnt  <= '0;
            beat_q  <= '0;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (calib_done && req_valid) begin
                        we_q    <= req_we;
                        len_q   <= req_len;
                        cmd_cnt <= '0;
                        rd_cnt  <= '0;
                        beat_q  <= '0;
                    end
                end
                WRITE_DATA2: begin
                    if (!last_cmd) begin
                        cmd_cnt <= cmd_cnt + CNT_ONE;
                        beat_q  <= beat_q + BEAT_ONE;
                    end
                end
                READ_DATA0: begin
                    if (app_rdy) cmd_cnt <= cmd_cnt + CNT_ONE;
                end
                default: ;
            endcase
            if (rd_phase && rd_data_valid) begin
                rd_cnt <= rd_cnt + CNT_ONE;
                beat_q <= rd_cnt[LENW-1:0];
            end
            if (timeout_hit) begin
                cmd_cnt <= '0;
                rd_cnt  <= '0;
                beat_q  <= '0;
            end
        end
    end

    always_comb begin
        req_ack      = 1'b0;
        app_en       = 1'b0;
        app_cmd      = 3'b000;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        done         = 1'b0;
        err          = timeout_hit;
        case (cur_state)
            PRESET1:     req_ack = 1'b1;
            WRITE_DATA0: begin
                app_wdf_wren = 1'b1;
                app_wdf_end  = 1'b1;
            end
            WRITE_DATA1: app_en = 1'b1;
            READ_DATA0:  begin
                app_en  = 1'b1;
                app_cmd = 3'b001;
            end
            WAIT_NACK:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mpmc10_state_seq.sv
// Self-checking bench for mpmc10_state_seq: transaction-level model of bursts against a random memory responder.
module tb_mpmc10_state_seq;
    localparam int LENW = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic            calib_done;
    logic            req_valid;
    logic            req_we;
    logic [LENW-1:0] req_len;
    logic            req_ack;
    logic            app_en;
    logic [2:0]      app_cmd;
    logic            app_rdy;
    logic            app_wdf_wren;
    logic            app_wdf_end;
    logic            app_wdf_rdy;
    logic            rd_data_valid;
    logic [LENW-1:0] beat_idx;
    logic [3:0]      state;
    logic            done;
    logic            err;

    int checkCount = 0;
    int errorCount = 0;

    mpmc10_state_seq #(.LENW(LENW), .TIMEOUT(1023)) dut (
        .clk(clk), .rstn(rstn), .calib_done(calib_done),
        .req_valid(req_valid), .req_we(req_we), .req_len(req_len), .req_ack(req_ack),
        .app_en(app_en), .app_cmd(app_cmd), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .rd_data_valid(rd_data_valid), .beat_idx(beat_idx), .state(state),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        app_rdy       = 1'b0;
        app_wdf_rdy   = 1'b0;
        rd_data_valid = 1'b0;
    endtask

    // Drives one request to completion; mode 0 random ready, 1 always ready, 2 stall 2nd read command twice.
    task automatic applyStimulus(input logic we, input int len, input int mode,
                                 input bit preAcked, input logic calibLevel);
        int  cycles    = 0;
        int  wrHs      = 0;
        int  cmdHs     = 0;
        int  beats     = 0;
        int  pend      = 0;
        int  acks      = preAcked ? 1 : 0;
        int  sinceAck  = preAcked ? 0 : -1;
        int  stallLeft = 2;
        int  beatCheck = -1;
        bit  finished  = 1'b0;
        req_we     = we;
        req_len    = len[LENW-1:0];
        calib_done = calibLevel;
        req_valid  = 1'b1;
        while (!finished && cycles < 300) begin
            @(negedge clk);
            cycles++;
            if (beatCheck >= 0) begin
                checkOutput("rd_beat_idx", beat_idx, beatCheck);
                beatCheck = -1;
            end
            if (mode == 0) begin
                app_rdy     = ($urandom_range(2) != 0);
                app_wdf_rdy = ($urandom_range(2) != 0);
            end else begin
                app_rdy     = 1'b1;
                app_wdf_rdy = 1'b1;
            end
            if (mode == 2 && cmdHs == 1 && app_en && stallLeft > 0) begin
                app_rdy = 1'b0;
                stallLeft--;
            end
            rd_data_valid = (pend > 0) && ($urandom_range(1) == 1);
            if (rd_data_valid) begin
                beatCheck = beats;
                beats++;
                pend--;
            end
            if (cycles == 1 && !preAcked) checkOutput("ack_latency", req_ack, 1);
            if (req_ack) begin
                acks++;
                sinceAck = 0;
                checkOutput("ack_state", state, 1);
            end else if (sinceAck >= 0 && sinceAck < 2) begin
                sinceAck++;
                if (sinceAck == 1) checkOutput("preset2_state", state, 2);
                else checkOutput("first_op_state", state, we ? 3 : 6);
            end
            if (!we) checkOutput("wren_on_read", app_wdf_wren, 0);
            if (app_wdf_wren) checkOutput("wdf_end", app_wdf_end, 1);
            if (app_en) checkOutput("app_en_state", (state == 4) || (state == 6), 1);
            if (app_wdf_wren && app_wdf_rdy) begin
                checkOutput("wr_beat_idx", beat_idx, wrHs);
                checkOutput("wr_before_cmd", wrHs, cmdHs);
                wrHs++;
            end
            if (app_en && app_rdy) begin
                checkOutput("app_cmd", app_cmd, we ? 0 : 1);
                if (we) begin
                    checkOutput("cmd_beat_idx", beat_idx, cmdHs);
                    checkOutput("cmd_after_data", wrHs, cmdHs + 1);
                end else begin
                    pend++;
                end
                cmdHs++;
            end
            checkOutput("err_low", err, 0);
            if (done) begin
                finished = 1'b1;
                checkOutput("done_state", state, 9);
                checkOutput("ack_count", acks, 1);
                checkOutput("wr_count", wrHs, we ? len + 1 : 0);
                checkOutput("cmd_count", cmdHs, len + 1);
                checkOutput("rd_count", beats, we ? 0 : len + 1);
            end
        end
        idleInputs();
        checkOutput("burst_budget", finished, 1);
        if (!finished) begin
            req_valid = 1'b0;
            rstn      = 1'b0;
            @(negedge clk);
            rstn      = 1'b1;
        end else begin
            @(negedge clk);
            checkOutput("done_held", done, 1);
            req_valid = 1'b0;
            @(negedge clk);
            checkOutput("idle_after_drop", state, 0);
            checkOutput("done_clear", done, 0);
        end
    endtask

    function automatic logic [31:0] outVec();
        return {18'd0, req_ack, app_en, app_cmd, app_wdf_wren, app_wdf_end, beat_idx, done, err};
    endfunction

    initial begin
        int  found;
        logic randWe;
        rstn       = 1'b0;
        calib_done = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_len    = '0;
        idleInputs();

        // Reset holds everything idle even with a request pending.
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_state", state, 0);
            checkOutput("reset_outputs", outVec(), 0);
        end
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_ack", req_ack, 1);
        checkOutput("post_reset_state1", state, 1);
        @(negedge clk);
        checkOutput("post_reset_state2", state, 2);
        checkOutput("post_reset_ack_low", req_ack, 0);
        rstn = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("abandon_state", state, 0);
        rstn = 1'b1;

        $display("[TB] directed write len=2, always ready");
        applyStimulus(1'b1, 2, 1, 1'b0, 1'b1);
        $display("[TB] directed read len=3, second command stalled");
        applyStimulus(1'b0, 3, 2, 1'b0, 1'b1);

        // Calibration gating, then drop calib_done mid-burst.
        calib_done = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_len    = 3'd1;
        repeat (10) begin
            @(negedge clk);
            checkOutput("calib_idle_state", state, 0);
            checkOutput("calib_no_ack", req_ack, 0);
        end
        calib_done = 1'b1;
        @(negedge clk);
        checkOutput("calib_ack", req_ack, 1);
        applyStimulus(1'b0, 1, 0, 1'b1, 1'b0);

        // Reset during WRITE_DATA1 of the second beat.
        req_we      = 1'b1;
        req_len     = 3'd3;
        calib_done  = 1'b1;
        req_valid   = 1'b1;
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            @(negedge clk);
            if (state == 4'd4 && beat_idx == 3'd1) found = 1;
        end
        checkOutput("reach_write_data1", found, 1);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("midreset_state", state, 0);
        checkOutput("midreset_app_en", app_en, 0);
        checkOutput("midreset_beat_idx", beat_idx, 0);
        rstn = 1'b1;
        idleInputs();
        applyStimulus(1'b1, 3, 0, 1'b0, 1'b1);

        $display("[TB] boundary lengths");
        applyStimulus(1'b1, 0, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
        applyStimulus(1'b1, 7, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 7, 0, 1'b0, 1'b1);

        $display("[TB] random bursts");
        for (int n = 0; n < 14; n++) begin
            randWe = 1'($urandom_range(1));
            applyStimulus(randWe, int'($urandom_range(7)), 0, 1'b0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mpmc10_state_seq.md
Name: mpmc10_state_seq

Overview:
- Command/data sequencer for the mpmc10 multi-port memory controller.
- Takes one granted request from the port arbiter and drives the MIG-style user interface (app_en / app_wdf_wren / rd_data_valid) through a burst of 1..2^LENW single-beat commands.
- Drives the 4-bit state code consumed by the controller's previous-state tracker and by the port response logic.

Parameters:
- LENW, 3: width of the burst-length field. Burst = req_len+1 commands.
- TIMEOUT, 1023: stall limit in cycles, used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  synchronous reset, active-low
- calib_done  in  1  memory calibration complete
- req_valid  in  1  arbiter request pending; held until done seen
- req_we  in  1  1=write burst, 0=read burst
- req_len  in  LENW  burst length minus one
- req_ack  out  1  one-cycle pulse: request accepted
- app_en  out  1  command valid to memory
- app_cmd  out  3  3'b000 write, 3'b001 read
- app_rdy  in  1  memory accepted command
- app_wdf_wren  out  1  write data valid
- app_wdf_end  out  1  equals app_wdf_wren (single-beat commands)
- app_wdf_rdy  in  1  memory accepted write data
- rd_data_valid  in  1  read beat returned
- beat_idx  out  LENW  index of current command (write) or returned beat (read)
- state  out  4  sequencer state code
- done  out  1  burst complete, held in WAIT_NACK
- err  out  1  one-cycle timeout pulse (0 when feature absent)

Behaviour:
- State codes: IDLE=0, PRESET1=1, PRESET2=2, WRITE_DATA0=3, WRITE_DATA1=4, WRITE_DATA2=5, READ_DATA0=6, READ_DATA1=7, READ_DATA2=8, WAIT_NACK=9. Codes 10-15 go to IDLE next cycle.
- Reset (rstn=0 at edge, including mid-burst): state=IDLE; all outputs 0; cmd_cnt=0, rd_cnt=0, beat_idx=0. Any burst in progress is abandoned.
- IDLE:
  - If calib_done && req_valid: latch req_we and req_len, pulse req_ack, clear counters, go to PRESET1.
  - Otherwise stay in IDLE.
- PRESET1 -> PRESET2: unconditional, one cycle of address setup.
- PRESET2: go to WRITE_DATA0 if we=1, else READ_DATA0.
- Write path (data is written before its command):
  - WRITE_DATA0: app_wdf_wren=1. On app_wdf_rdy, go to WRITE_DATA1.
  - WRITE_DATA1: app_en=1, app_cmd=000. On app_rdy, go to WRITE_DATA2.
  - WRITE_DATA2: if cmd_cnt==len, go to WAIT_NACK. Otherwise cmd_cnt++, beat_idx++, go to WRITE_DATA0.
- Read path:
  - READ_DATA0: app_en=1, app_cmd=001. On app_rdy: cmd_cnt++. If cmd_cnt==len at that edge, go to READ_DATA1; else stay.
  - In READ_DATA0 and READ_DATA1, each rd_data_valid increments rd_cnt; beat_idx = rd_cnt before the increment.
  - READ_DATA1: when the (len+1)th beat arrives, go to READ_DATA2. A beat arriving on the same edge as the transition is counted.
  - READ_DATA2: one cycle, then WAIT_NACK.
- WAIT_NACK: done=1. When req_valid=0, go to IDLE; done clears on that edge.
- Outputs are combinational decodes of registered state. app_en never asserts outside WRITE_DATA1/READ_DATA0; app_wdf_wren never asserts outside WRITE_DATA0.
- Counters are LENW+1 bits wide, so len=2^LENW-1 does not wrap before the compare.
- calib_done is sampled only in IDLE; a drop mid-burst has no effect.

Optional Feature:
- Macro: MPMC10_SEQ_TIMEOUT_EN.
- Defined:
  - A stall counter clears on every state change and in IDLE/WAIT_NACK, and increments otherwise.
  - When it reaches TIMEOUT: pulse err for one cycle, force state to IDLE, clear counters. done is not asserted.
- Undefined: no counter; err tied to 0; the sequencer may wait indefinitely on app_rdy, app_wdf_rdy or rd_data_valid.

Test Plan:
- Reset with req_valid=1 and calib_done=1: state=0 and all outputs 0 while rstn=0. req_ack occurs on the first edge after rstn=1; state then goes 1, 2.
- Write, req_len=2, app_rdy and app_wdf_rdy always 1: three wren pulses and three app_en pulses with cmd=000, beat_idx 0,1,2. Then state=9, done=1; drop req_valid -> state=0.
- Read, req_len=3, app_rdy low for 2 cycles on the second command, rd_data_valid beats arriving during READ_DATA0: exactly 4 app_en handshakes, rd_cnt=4, state sequence 6 -> 7 -> 8 -> 9.
- calib_done=0 with req_valid=1 for 10 cycles: stays IDLE, no req_ack. Raise calib_done: ack the next cycle.
- rstn pulsed low during WRITE_DATA1: state=0 on the next edge, app_en=0, counters 0. A new request restarts at beat_idx=0.
- MPMC10_SEQ_TIMEOUT_EN with TIMEOUT=16 and app_rdy held 0 in READ_DATA0: err pulses exactly once, 16 cycles after entry; state=0 next cycle, done stays 0.
